// File: rtl/apb_slave_exe_ctrl_if.sv
// APB3 bus bundle between the interconnect (master) and apb_slave_exe_ctrl (slave).
// Signal names keep the i_/o_ direction prefixes as seen from the slave.
interface apb_slave_exe_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] i_PADDR;
  logic                  i_PSEL;
  logic                  i_PENABLE;
  logic                  i_PWRITE;
  logic [DATA_WIDTH-1:0] i_PWDATA;
  logic                  o_PREADY;
  logic [DATA_WIDTH-1:0] o_PRDATA;
  logic                  o_PSLVERR;

  modport slave (
    input  i_PADDR, i_PSEL, i_PENABLE, i_PWRITE, i_PWDATA,
    output o_PREADY, o_PRDATA, o_PSLVERR
  );

  modport master (
    output i_PADDR, i_PSEL, i_PENABLE, i_PWRITE, i_PWDATA,
    input  o_PREADY, o_PRDATA, o_PSLVERR
  );
endinterface

// File: rtl/apb_slave_exe_ctrl.sv
// APB3 slave front-end for a multi-cycle exe unit: operand registers, start/busy/done sequencer,
// result capture and read wait states. Optional macro EXE_IRQ_EN adds o_IRQ and CTRL bit2 IRQ_EN.
module apb_slave_exe_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int EXE_LATENCY  = 2,
  parameter int STATUS_WIDTH = 4
) (
  input  logic                    i_PCLK,
  input  logic                    i_PRESETn,
  apb_slave_exe_ctrl_if.slave     apb,
  output logic [DATA_WIDTH-1:0]   o_EXE_OPER,
  output logic [DATA_WIDTH-1:0]   o_EXE_ARGA,
  output logic [DATA_WIDTH-1:0]   o_EXE_ARGB,
  input  logic [DATA_WIDTH-1:0]   i_EXE_RESULT,
  input  logic [STATUS_WIDTH-1:0] i_EXE_STATUS
`ifdef EXE_IRQ_EN
  ,
  output logic                    o_IRQ
`endif
);

  localparam int CNT_W = $clog2(EXE_LATENCY + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  seq_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   oper_q, oper_d;
  logic [DATA_WIDTH-1:0]   arga_q, arga_d;
  logic [DATA_WIDTH-1:0]   argb_q, argb_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic [STATUS_WIDTH-1:0] status_q, status_d;
  logic                    done_q, done_d;
`ifdef EXE_IRQ_EN
  logic                    irq_en_q, irq_en_d;
  logic                    irq_q, irq_d;
`endif

  logic [2:0]            idx;
  logic                  out_of_range;
  logic                  access;
  logic                  is_write;
  logic                  busy;
  logic                  rd_wait;
  logic                  err;
  logic                  ready;
  logic                  fire;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] status_word;
  logic [DATA_WIDTH-1:0] rdata;

  assign idx          = apb.i_PADDR[2:0];
  assign out_of_range = |apb.i_PADDR[ADDR_WIDTH-1:3];
  assign access       = apb.i_PSEL & apb.i_PENABLE;
  assign is_write     = apb.i_PWRITE;
  assign wdata        = apb.i_PWDATA;
  assign busy         = (state_q == RUN);

  // A RESULT/STATUS read during a computation stalls until the cycle after capture.
  assign rd_wait = ~is_write & busy & ~out_of_range & ((idx == 3'd4) | (idx == 3'd5));
  assign ready   = i_PRESETn & access & ~rd_wait;
  assign fire    = ready & ~err & is_write;

  assign apb.o_PREADY  = ready;
  assign apb.o_PSLVERR = ready & err;
  assign apb.o_PRDATA  = (ready & ~err & ~is_write) ? rdata : '0;

  assign o_EXE_OPER = oper_q;
  assign o_EXE_ARGA = arga_q;
  assign o_EXE_ARGB = argb_q;
`ifdef EXE_IRQ_EN
  assign o_IRQ = irq_q;
`endif

  always_comb begin
    err = 1'b0;
    case (idx)
      3'd0, 3'd1, 3'd2: err = is_write & busy;
      3'd3:             err = ~is_write | (busy & (wdata[0] | wdata[1]));
      3'd4, 3'd5, 3'd6: err = is_write;
      default:          err = 1'b1;
    endcase
    if (out_of_range) begin
      err = 1'b1;
    end
  end

  always_comb begin
    status_word                    = '0;
    status_word[STATUS_WIDTH-1:0]  = status_q;
    status_word[STATUS_WIDTH]      = busy;
    status_word[STATUS_WIDTH+1]    = done_q;
`ifdef EXE_IRQ_EN
    status_word[DATA_WIDTH-1]      = irq_en_q;
`endif
  end

  always_comb begin
    rdata = '0;
    case (idx)
      3'd0:    rdata = oper_q;
      3'd1:    rdata = arga_q;
      3'd2:    rdata = argb_q;
      3'd4:    rdata = result_q;
      3'd5:    rdata = status_word;
      3'd6:    rdata = DATA_WIDTH'(8'hA5);
      default: rdata = '0;
    endcase
  end

  // Register writes and sequencer; START in RUN never reaches here because it is an error.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    oper_d   = oper_q;
    arga_d   = arga_q;
    argb_d   = argb_q;
    result_d = result_q;
    status_d = status_q;
    done_d   = done_q;
`ifdef EXE_IRQ_EN
    irq_en_d = irq_en_q;
    irq_d    = done_q & irq_en_q;
`endif

    if (state_q == RUN) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d  = IDLE;
        result_d = i_EXE_RESULT;
        status_d = i_EXE_STATUS;
        done_d   = 1'b1;
      end
    end

    if (fire) begin
      case (idx)
        3'd0: oper_d = wdata;
        3'd1: arga_d = wdata;
        3'd2: argb_d = wdata;
        3'd3: begin
          if (wdata[1]) begin
            done_d = 1'b0;
          end
`ifdef EXE_IRQ_EN
          irq_en_d = wdata[2];
`endif
          if (wdata[0]) begin
            state_d = RUN;
            cnt_d   = CNT_W'(EXE_LATENCY);
            done_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      oper_q   <= '0;
      arga_q   <= '0;
      argb_q   <= '0;
      result_q <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
`ifdef EXE_IRQ_EN
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      oper_q   <= oper_d;
      arga_q   <= arga_d;
      argb_q   <= argb_d;
      result_q <= result_d;
      status_q <= status_d;
      done_q   <= done_d;
`ifdef EXE_IRQ_EN
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_slave_exe_ctrl.sv
// Self-checking bench for apb_slave_exe_ctrl: directed register-map scenarios plus random APB
// traffic, compared every cycle against a timestamp-based behavioural model of the block.
module tb_apb_slave_exe_ctrl;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int L  = 2;
  localparam int SW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  apb_slave_exe_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic [DW-1:0] exe_oper, exe_arga, exe_argb, exe_result;
  logic [SW-1:0] exe_status;
`ifdef EXE_IRQ_EN
  logic irq;
`endif

  // Stand-in exe unit: result = A + B, status = OPER[3:0] ^ 1.
  assign exe_result = exe_arga + exe_argb;
  assign exe_status = exe_oper[SW-1:0] ^ SW'(1);

  apb_slave_exe_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .EXE_LATENCY(L), .STATUS_WIDTH(SW)
  ) dut (
    .i_PCLK       (clk),
    .i_PRESETn    (rst_n),
    .apb          (bus),
    .o_EXE_OPER   (exe_oper),
    .o_EXE_ARGA   (exe_arga),
    .o_EXE_ARGB   (exe_argb),
    .i_EXE_RESULT (exe_result),
    .i_EXE_STATUS (exe_status)
`ifdef EXE_IRQ_EN
    ,
    .o_IRQ        (irq)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state; busy ends at an absolute cycle number rather than a countdown.
  logic [DW-1:0] m_oper = '0, m_arga = '0, m_argb = '0, m_result = '0;
  logic [SW-1:0] m_status = '0;
  logic          m_done = 1'b0, m_busy = 1'b0, m_irq_en = 1'b0, m_irq = 1'b0;
  int            m_cyc = 0;
  int            m_capture_at = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [2:0] i);
    logic irq_bit;
`ifdef EXE_IRQ_EN
    irq_bit = m_irq_en;
`else
    irq_bit = 1'b0;
`endif
    case (i)
      3'd0:    return m_oper;
      3'd1:    return m_arga;
      3'd2:    return m_argb;
      3'd4:    return m_result;
      3'd5:    return {irq_bit, 1'b0, m_done, m_busy, m_status};
      3'd6:    return 8'hA5;
      default: return '0;
    endcase
  endfunction

  // Expected bus response for the current inputs, written straight from the register-map rules.
  function automatic void model_bus(output logic ready, output logic err, output logic [DW-1:0] rdata);
    logic [2:0]    i;
    logic          oor, wr, hold;
    logic [DW-1:0] wd;
    i    = bus.i_PADDR[2:0];
    oor  = (bus.i_PADDR[AW-1:3] != '0);
    wr   = bus.i_PWRITE;
    wd   = bus.i_PWDATA;
    err  = oor || (i == 3'd7) || (wr && i >= 3'd4 && i <= 3'd6) || (!wr && i == 3'd3)
           || (wr && i <= 3'd2 && m_busy) || (wr && i == 3'd3 && m_busy && (wd[0] || wd[1]));
    hold = !wr && !oor && m_busy && (i == 3'd4 || i == 3'd5);
    ready = bus.i_PSEL && bus.i_PENABLE && !hold;
    rdata = (ready && !err && !wr) ? model_read(i) : '0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic          rdy, er, irq_next;
    logic [DW-1:0] rd, wd;
    if (!rst_n) begin
      m_oper = '0; m_arga = '0; m_argb = '0; m_result = '0; m_status = '0;
      m_done = 1'b0; m_busy = 1'b0; m_irq_en = 1'b0; m_irq = 1'b0;
      m_cyc = 0; m_capture_at = 0;
    end else begin
      irq_next = m_done && m_irq_en;
      model_bus(rdy, er, rd);
      wd = bus.i_PWDATA;
      if (m_busy && (m_cyc + 1 == m_capture_at)) begin
        m_result = m_arga + m_argb;
        m_status = m_oper[SW-1:0] ^ SW'(1);
        m_busy   = 1'b0;
        m_done   = 1'b1;
      end
      if (rdy && !er && bus.i_PWRITE) begin
        case (bus.i_PADDR[2:0])
          3'd0: m_oper = wd;
          3'd1: m_arga = wd;
          3'd2: m_argb = wd;
          3'd3: begin
            if (wd[1]) m_done = 1'b0;
`ifdef EXE_IRQ_EN
            m_irq_en = wd[2];
`endif
            if (wd[0]) begin
              m_busy       = 1'b1;
              m_done       = 1'b0;
              m_capture_at = m_cyc + 1 + L;
            end
          end
          default: ;
        endcase
      end
      m_irq = irq_next;
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    logic          rdy, er;
    logic [DW-1:0] rd;
    if (!rst_n) begin
      checkOutput("rst_pready", bus.o_PREADY, 0);
      checkOutput("rst_pslverr", bus.o_PSLVERR, 0);
      checkOutput("rst_prdata", bus.o_PRDATA, 0);
      checkOutput("rst_arga", exe_arga, 0);
    end else begin
      model_bus(rdy, er, rd);
      checkOutput("pready", bus.o_PREADY, rdy);
      checkOutput("pslverr", bus.o_PSLVERR, rdy && er);
      if (!(bus.i_PSEL && bus.i_PENABLE && bus.i_PWRITE))
        checkOutput("prdata", bus.o_PRDATA, rd);
      checkOutput("exe_oper", exe_oper, m_oper);
      checkOutput("exe_arga", exe_arga, m_arga);
      checkOutput("exe_argb", exe_argb, m_argb);
`ifdef EXE_IRQ_EN
      checkOutput("irq", irq, m_irq);
`endif
    end
  end

  // One APB transfer starting 1ns after a rising edge; returns 1ns after its completing edge.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                               output logic [DW-1:0] rd, output logic er, output int waits);
    logic got;
    got = 1'b0; rd = '0; er = 1'b0; waits = 0;
    bus.i_PSEL = 1'b1; bus.i_PENABLE = 1'b0;
    bus.i_PWRITE = wr; bus.i_PADDR = addr; bus.i_PWDATA = wd;
    @(posedge clk); #1;
    bus.i_PENABLE = 1'b1;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (bus.o_PREADY) begin
        rd = bus.o_PRDATA; er = bus.o_PSLVERR; got = 1'b1;
        break;
      end
      waits++;
    end
    @(posedge clk); #1;
    bus.i_PSEL = 1'b0; bus.i_PENABLE = 1'b0;
    if (!got) checkOutput("xfer_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    logic          er;
    int            w;
    logic [AW-1:0] addr;

    // Drive an access phase during reset to show the bus outputs stay gated.
    bus.i_PSEL = 1'b1; bus.i_PENABLE = 1'b1; bus.i_PWRITE = 1'b0;
    bus.i_PADDR = 16'h0006; bus.i_PWDATA = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.i_PSEL = 1'b0; bus.i_PENABLE = 1'b0;
    rst_n = 1'b1;
    idle(1);

    applyStimulus(0, 16'h0006, 0, rd, er, w);
    checkOutput("id_data", rd, 8'hA5);
    checkOutput("id_err", er, 0);
    checkOutput("id_waits", w, 0);
    applyStimulus(0, 16'h0005, 0, rd, er, w);
    checkOutput("status_after_reset", rd, 8'h00);

    applyStimulus(1, 16'h0000, 8'h03, rd, er, w);
    applyStimulus(1, 16'h0001, 8'h12, rd, er, w);
    applyStimulus(1, 16'h0002, 8'h34, rd, er, w);
    applyStimulus(1, 16'h0003, 8'h01, rd, er, w);
    checkOutput("start_err", er, 0);
    idle(3);
    applyStimulus(0, 16'h0005, 0, rd, er, w);
    checkOutput("status_done", rd, 8'h22);
    applyStimulus(0, 16'h0004, 0, rd, er, w);
    checkOutput("result_46", rd, 8'h46);

    // Back-to-back: START then RESULT read; setup cycle plus one wait cycle with PREADY low.
    applyStimulus(1, 16'h0003, 8'h01, rd, er, w);
    applyStimulus(0, 16'h0004, 0, rd, er, w);
    checkOutput("wait_result_data", rd, 8'h46);
    checkOutput("wait_result_err", er, 0);
    checkOutput("wait_result_waits", w, 1);

    applyStimulus(1, 16'h0003, 8'h01, rd, er, w);
    applyStimulus(1, 16'h0001, 8'hFF, rd, er, w);
    checkOutput("busy_arga_err", er, 1);
    idle(3);
    applyStimulus(1, 16'h0003, 8'h01, rd, er, w);
    applyStimulus(1, 16'h0003, 8'h03, rd, er, w);
    checkOutput("busy_start_err", er, 1);
    idle(3);
    applyStimulus(0, 16'h0001, 0, rd, er, w);
    checkOutput("arga_kept", rd, 8'h12);
    applyStimulus(0, 16'h0005, 0, rd, er, w);
    checkOutput("status_after_busy_err", rd, 8'h22);

    applyStimulus(0, 16'h0003, 0, rd, er, w);
    checkOutput("read_ctrl_err", er, 1);
    checkOutput("read_ctrl_data", rd, 0);
    applyStimulus(0, 16'h0100, 0, rd, er, w);
    checkOutput("oor_err", er, 1);
    checkOutput("oor_data", rd, 0);
    applyStimulus(1, 16'h0004, 8'h77, rd, er, w);
    checkOutput("write_result_err", er, 1);
    applyStimulus(0, 16'h0007, 0, rd, er, w);
    checkOutput("idx7_err", er, 1);
    applyStimulus(0, 16'h0004, 0, rd, er, w);
    checkOutput("result_unchanged", rd, 8'h46);

    for (int n = 0; n < 300; n++) begin
      addr = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) addr[AW-1:3] = 13'($urandom_range(1, 8191));
      applyStimulus(1'($urandom_range(0, 1)), addr, DW'($urandom), rd, er, w);
      idle($urandom_range(0, 2));
    end

    idle(4);
    applyStimulus(1, 16'h0001, 8'h05, rd, er, w);
    applyStimulus(1, 16'h0002, 8'h06, rd, er, w);
    applyStimulus(1, 16'h0003, 8'h01, rd, er, w);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(L + 3);
    applyStimulus(0, 16'h0005, 0, rd, er, w);
    checkOutput("status_after_midrun_reset", rd, 8'h00);
    applyStimulus(0, 16'h0004, 0, rd, er, w);
    checkOutput("result_after_midrun_reset", rd, 8'h00);
    applyStimulus(0, 16'h0001, 0, rd, er, w);
    checkOutput("arga_after_midrun_reset", rd, 8'h00);

`ifdef EXE_IRQ_EN
    applyStimulus(1, 16'h0000, 8'h03, rd, er, w);
    applyStimulus(1, 16'h0001, 8'h01, rd, er, w);
    applyStimulus(1, 16'h0002, 8'h01, rd, er, w);
    applyStimulus(1, 16'h0003, 8'h05, rd, er, w);
    idle(1);
    checkOutput("irq_busy", irq, 0);
    idle(1);
    checkOutput("irq_capture_cycle", irq, 0);
    idle(1);
    checkOutput("irq_set", irq, 1);
    applyStimulus(0, 16'h0005, 0, rd, er, w);
    checkOutput("status_irq_en", rd, 8'hA2);
    applyStimulus(1, 16'h0003, 8'h02, rd, er, w);
    checkOutput("irq_before_clear", irq, 1);
    idle(1);
    checkOutput("irq_cleared", irq, 0);
`endif

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
